ascon_round_engine: RTL and testbench

- Iterative ASCON permutation engine: full round p_c -> p_s -> p_l, with an internal round counter driving the constant addition.
- Selectable rounds per permutation: p^a = 12, p^b = 8 or 6. UNROLL rounds are applied per clock.
- Sits between the ASCON mode FSM and the state register. Replaces the purely combinational single-round constant-addition path.

---
 rtl/ascon_round_engine.sv | 131 +++++++++++++
 tb/tb_ascon_round_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ascon_round_engine.sv
// Iterative ASCON permutation: UNROLL rounds (p_c -> p_s -> p_l) per clock, 6/8/12 rounds per run.
// State layout: S0 = state[319:256], S1 = [255:192], S2 = [191:128], S3 = [127:64], S4 = [63:0].
module ascon_round_engine #(
  parameter int UNROLL  = 1,
  parameter bit PC_ONLY = 1'b0
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [3:0]   nb_rounds_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [319:0] state_q, state_d, rnd_state;
  logic [3:0]   round_q, round_d, round_nxt;
  logic         done_q, done_d, err_q, err_d;
  logic         nb_legal;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  c;
    c  = {4'd15 - r, r};
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, c};
    x3 = s[127:64];
    x4 = s[63:0];
    if (!PC_ONLY) begin
      // Bitsliced S-box: all 64 columns in parallel
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  assign nb_legal  = (nb_rounds_i == 4'd6) || (nb_rounds_i == 4'd8) || (nb_rounds_i == 4'd12);
  assign round_nxt = round_q + 4'(UNROLL);

  always_comb begin
    rnd_state = state_q;
    for (int u = 0; u < UNROLL; u++) begin
      rnd_state = round_fn(rnd_state, round_q + 4'(u));
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (fsm_q)
      IDLE, DONE: begin
        if (start_i) begin
          if (nb_legal) begin
            state_d = state_i;
            round_d = 4'd12 - nb_rounds_i;
            fsm_d   = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        state_d = rnd_state;
        round_d = round_nxt;
        if (round_nxt == 4'd12) begin
          fsm_d  = DONE;
          done_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = (fsm_q == RUN);
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_ascon_round_engine.sv
// Bench for ascon_round_engine: four configurations (UNROLL 1/2 x PC_ONLY 0/1) driven in parallel,
// checked against a table-driven reference permutation through an expected-result queue.
module tb_ascon_round_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   nb_rounds;
  logic [319:0] state_in;

  logic [319:0] so [4];
  logic [3:0]   ro [4];
  logic         bo [4];
  logic         dn [4];
  logic         er [4];

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [319:0] st;
    int           lat;
  } exp_t;
  exp_t exp_q[$];

  logic [319:0] prev_st [4];
  logic [3:0]   prev_round;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 clk = ~clk;

  ascon_round_engine #(.UNROLL(1), .PC_ONLY(1'b0)) u0 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_rounds_i(nb_rounds), .state_i(state_in),
    .state_o(so[0]), .round_o(ro[0]), .busy_o(bo[0]), .done_o(dn[0]), .err_o(er[0]));
  ascon_round_engine #(.UNROLL(2), .PC_ONLY(1'b0)) u1 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_rounds_i(nb_rounds), .state_i(state_in),
    .state_o(so[1]), .round_o(ro[1]), .busy_o(bo[1]), .done_o(dn[1]), .err_o(er[1]));
  ascon_round_engine #(.UNROLL(1), .PC_ONLY(1'b1)) u2 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_rounds_i(nb_rounds), .state_i(state_in),
    .state_o(so[2]), .round_o(ro[2]), .busy_o(bo[2]), .done_o(dn[2]), .err_o(er[2]));
  ascon_round_engine #(.UNROLL(2), .PC_ONLY(1'b1)) u3 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .nb_rounds_i(nb_rounds), .state_i(state_in),
    .state_o(so[3]), .round_o(ro[3]), .busy_o(bo[3]), .done_o(dn[3]), .err_o(er[3]));

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] ref_round(input logic [319:0] s, input int r, input bit pc);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v, o;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
    if (!pc) begin
      for (int j = 0; j < 64; j++) begin
        v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = SBOX[v];
        for (int i = 0; i < 5; i++) y[i][j] = o[4 - i];
      end
      x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
      x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
      x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
      x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
      x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nb, input bit pc);
    logic [319:0] t;
    t = s;
    for (int r = 12 - nb; r < 12; r++) t = ref_round(t, r, pc);
    return t;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_state_u%0d", tag, k), so[k], '0);
      chk($sformatf("%s_round_u%0d", tag, k), 320'(ro[k]), '0);
      chk($sformatf("%s_ctl_u%0d", tag, k), 320'({bo[k], dn[k], er[k]}), '0);
    end
  endtask

  // mid > 0 pulses start again while the engines are still running
  task automatic run(input logic [3:0] nb, input logic [319:0] st, input int mid);
    int         dcnt [4];
    int         dlat [4];
    int         bcnt [4];
    logic [3:0] r1   [4];
    exp_t       e;
    for (int k = 0; k < 4; k++) begin
      e.st  = ref_perm(st, int'(nb), k >= 2);
      e.lat = int'(nb) / ((k % 2 == 1) ? 2 : 1);
      exp_q.push_back(e);
      dcnt[k] = 0; dlat[k] = -1; bcnt[k] = 0; r1[k] = '0;
    end
    @(negedge clk);
    start = 1'b1; nb_rounds = nb; state_in = st;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (mid > 0 && i == mid) start = 1'b1;
      if (mid > 0 && i == mid + 1) start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (i == 1) r1[k] = ro[k];
        if (bo[k]) bcnt[k]++;
        if (dn[k]) begin
          dcnt[k]++;
          dlat[k] = i - 1;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("state_nb%0d_u%0d", nb, k), so[k], e.st);
      chk($sformatf("latency_nb%0d_u%0d", nb, k), 320'(dlat[k]), 320'(e.lat));
      chk($sformatf("busy_cycles_nb%0d_u%0d", nb, k), 320'(bcnt[k]), 320'(e.lat));
      chk($sformatf("done_pulses_nb%0d_u%0d", nb, k), 320'(dcnt[k]), 320'(1));
      chk($sformatf("round_final_nb%0d_u%0d", nb, k), 320'(ro[k]), 320'(12));
      chk($sformatf("round_first_nb%0d_u%0d", nb, k), 320'(r1[k]), 320'(4'd12 - nb));
      prev_st[k] = e.st;
    end
    prev_round = 4'd12;
  endtask

  task automatic bad_start(input logic [3:0] nb);
    @(negedge clk);
    start = 1'b1; nb_rounds = nb; state_in = rand320();
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("err_pulse_nb%0d_u%0d", nb, k), 320'({er[k], bo[k]}), 320'(2'b10));
      chk($sformatf("err_state_held_u%0d", k), so[k], prev_st[k]);
      chk($sformatf("err_round_held_u%0d", k), 320'(ro[k]), 320'(prev_round));
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("err_cleared_u%0d", k), 320'({er[k], bo[k], dn[k]}), '0);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    start = 1'b1; nb_rounds = 4'd12; state_in = rand320();
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("busy_before_reset_u%0d", k), 320'({bo[k], dn[k]}), 320'(2'b10));
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    chk_zero("reset_held");
    rst_n = 1'b1;
    repeat (14) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        chk($sformatf("no_done_after_abort_u%0d", k), 320'({dn[k], bo[k]}), '0);
    end
    for (int k = 0; k < 4; k++) prev_st[k] = '0;
    prev_round = 4'd0;
  endtask

  initial begin
    logic [3:0] nbs [3];
    nbs[0] = 4'd12; nbs[1] = 4'd8; nbs[2] = 4'd6;
    rst_n = 1'b0; start = 1'b0; nb_rounds = 4'd12; state_in = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(4'd12, '0, 0);
    run(4'd6, '0, 0);
    run(4'd8, '0, 0);
    bad_start(4'd7);
    for (int i = 0; i < 6; i++) run(nbs[i % 3], rand320(), 0);
    run(4'd12, rand320(), 3);
    bad_start(4'd15);
    reset_mid_run();
    bad_start(4'd7);
    run(4'd12, rand320(), 0);
    run(4'd6, rand320(), 0);
    chk("queue_drained", 320'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
